// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and sizing helpers for the I2S transmit sequencer
package i2s_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DATA_W_DEF     = 16;
    localparam int DIV_W_DEF      = 8;
    localparam int FRAME_BITS_DEF = 2 * DATA_W_DEF;

    function automatic int frame_len(input int data_w);
        return 2 * data_w;
    endfunction

    // Slot index must cover every bit position of a stereo frame.
    function automatic int slot_w(input int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - programmable bit-clock divider with SCK edge strobes
module i2s_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sck_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             tc;

    // Strobes fire in the cycle whose closing edge toggles SCK, so the
    // sequencer can update WS/SD on exactly the same edge as the fall.
    always_comb begin
        tc    = run_i && (cnt_q == div_i);
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!run_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tc) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = tc & ~sck_q;
    assign fall_o = tc & sck_q;

endmodule

// File: rtl/i2s_tx_sequencer.sv
// rtl/i2s_tx_sequencer.sv - I2S transmit frame controller with one-entry sample buffer
module i2s_tx_sequencer
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [DIV_W-1:0]      i_clk_div,
    input  logic                  i_sample_valid,
    input  logic [2*DATA_W-1:0]   i_sample_data,
    output logic                  o_sample_ready,
    output logic                  o_sck,
    output logic                  o_ws,
    output logic                  o_sd,
    output logic                  o_busy,
    output logic                  o_underrun,
    input  logic                  i_underrun_clr
);

    localparam int FRAME_W = frame_len(DATA_W);
    localparam int SLOT_W  = slot_w(DATA_W);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
    localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(DATA_W - 1);
    localparam logic [SLOT_W-1:0] WS_LAST   = SLOT_W'(FRAME_W - 2);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 underrun_q, underrun_d;
    logic                 accept;
    logic                 sck;
    logic                 sck_fall;
    logic                 sck_rise_unused;

    i2s_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .run_i  (state_q == ST_RUN),
        .div_i  (div_q),
        .sck_o  (sck),
        .rise_o (sck_rise_unused),
        .fall_o (sck_fall)
    );

    always_comb begin
        accept     = i_sample_valid && !buf_full_q;
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        slot_d     = slot_q;
        div_d      = div_q;
        underrun_d = i_underrun_clr ? 1'b0 : underrun_q;

        if (accept) begin
            buf_d      = i_sample_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable && buf_full_q) begin
                    state_d    = ST_RUN;
                    div_d      = i_clk_div;
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    slot_d     = '0;
                end
            end
            ST_RUN: begin
                if (sck_fall) begin
                    if (slot_q == SLOT_LAST) begin
                        // Frame boundary: stop, reload, or send silence on underrun.
                        slot_d = '0;
                        if (!i_enable) begin
                            state_d = ST_IDLE;
                            shift_d = '0;
                        end else if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                        end else begin
                            shift_d    = '0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            slot_q     <= '0;
            div_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            slot_q     <= slot_d;
            div_q      <= div_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_busy         = (state_q == ST_RUN);
    assign o_sample_ready = !buf_full_q;
    assign o_sck          = sck;
    assign o_sd           = o_busy && shift_q[FRAME_W-1];
    assign o_ws           = o_busy && (slot_q >= WS_FIRST) && (slot_q <= WS_LAST);
    assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// tb/tb_i2s_tx_sequencer.sv - scoreboard bench for the I2S transmit sequencer
module tb_i2s_tx_sequencer;

    localparam int DATA_W = 16;
    localparam int DIV_W  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_enable = 1'b0;
    logic [DIV_W-1:0]    i_clk_div = 8'd1;
    logic                i_sample_valid = 1'b0;
    logic [2*DATA_W-1:0] i_sample_data = '0;
    logic                i_underrun_clr = 1'b0;
    logic                o_sample_ready, o_sck, o_ws, o_sd, o_busy, o_underrun;

    int vectors     = 0;
    int miscompares = 0;
    int rises       = 0;
    int cyc         = 0;
    int exp_period  = 4;
    logic [1:0] exp_q[$];

    i2s_tx_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (i_enable),
        .i_clk_div      (i_clk_div),
        .i_sample_valid (i_sample_valid),
        .i_sample_data  (i_sample_data),
        .o_sample_ready (o_sample_ready),
        .o_sck          (o_sck),
        .o_ws           (o_ws),
        .o_sd           (o_sd),
        .o_busy         (o_busy),
        .o_underrun     (o_underrun),
        .i_underrun_clr (i_underrun_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ws_of(input int s);
        return (s >= DATA_W - 1) && (s <= 2 * DATA_W - 2);
    endfunction

    task automatic push_bits(input logic [31:0] d);
        for (int s = 0; s < 2 * DATA_W; s++)
            exp_q.push_back({ws_of(s), d[31-s]});
    endtask

    // Called at a negedge; leaves at the negedge after the transfer edge.
    task automatic push_sample(input logic [31:0] d);
        int n;
        n = 0;
        i_sample_valid = 1'b1;
        i_sample_data  = d;
        while (!o_sample_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("accept timeout", 32'(n < 600), 32'd1);
        @(negedge clk);
        i_sample_valid = 1'b0;
        push_bits(d);
    endtask

    task automatic wait_ready_rise(input logic msb);
        int n;
        n = 0;
        while (!o_sample_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("ready timeout", 32'(n < 600), 32'd1);
        check("load sd msb", 32'(o_sd), 32'(msb));
        check("load ws", 32'(o_ws), 32'd0);
        check("load sck", 32'(o_sck), 32'd0);
        check("stream underrun", 32'(o_underrun), 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle busy", 32'(o_busy), 32'd0);
        check("idle outputs", {29'd0, o_sck, o_ws, o_sd}, 32'd0);
        check("queue drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every SCK rise consumes one expected {ws, sd} bit and checks the period.
    initial begin
        logic       prev_sck;
        logic [1:0] e;
        int         last;
        bit         have;
        prev_sck = 1'b0;
        last     = 0;
        have     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!o_busy) have = 1'b0;
            if (o_sck && !prev_sck) begin
                rises++;
                if (have) check("sck period", 32'(cyc - last), 32'(exp_period));
                have = 1'b1;
                last = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ws/sd bit", {30'd0, o_ws, o_sd}, {30'd0, e});
                end
            end
            prev_sck = o_sck;
        end
    end

    initial begin
        int base;
        int n;

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst outputs", {28'd0, o_sck, o_ws, o_sd, o_busy}, 32'd0);
        check("rst underrun", 32'(o_underrun), 32'd0);
        check("rst ready", 32'(o_sample_ready), 32'd1);

        // Single frame followed by two underrun frames
        i_clk_div  = 8'd1;
        exp_period = 4;
        push_sample(32'hA5A5_3C3C);
        push_bits(32'h0);
        push_bits(32'h0);
        base = rises;
        i_enable = 1'b1;
        n = 0;
        while (!o_underrun && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("underrun timeout", 32'(n < 600), 32'd1);
        check("bits before underrun", 32'(rises - base), 32'd32);
        check("underrun busy", 32'(o_busy), 32'd1);
        repeat (20) @(negedge clk);
        i_underrun_clr = 1'b1;
        @(negedge clk);
        i_underrun_clr = 1'b0;
        check("underrun clear", 32'(o_underrun), 32'd0);
        repeat (106) @(negedge clk);
        i_underrun_clr = 1'b1;
        @(negedge clk);
        i_underrun_clr = 1'b0;
        i_enable = 1'b0;
        check("set beats clear", 32'(o_underrun), 32'd1);
        wait_idle();

        // Streaming at div=0
        i_underrun_clr = 1'b1;
        @(negedge clk);
        i_underrun_clr = 1'b0;
        check("idle clear", 32'(o_underrun), 32'd0);
        i_clk_div  = 8'd0;
        exp_period = 2;
        push_sample(32'h0F0F_F0F0);
        i_enable = 1'b1;
        push_sample(32'h8000_0001);
        wait_ready_rise(1'b1);
        push_sample(32'h7FFF_FFFE);
        wait_ready_rise(1'b0);
        push_sample(32'hDEAD_BEEF);
        wait_ready_rise(1'b1);
        i_enable = 1'b0;
        wait_idle();
        check("stream no underrun", 32'(o_underrun), 32'd0);

        // Disable at slot 10, divider change ignored while busy
        i_clk_div  = 8'd1;
        exp_period = 4;
        push_sample(32'h1234_8001);
        base = rises;
        i_enable = 1'b1;
        n = 0;
        while (rises < base + 11 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("slot10 timeout", 32'(n < 600), 32'd1);
        i_enable  = 1'b0;
        i_clk_div = 8'd3;
        wait_idle();
        check("full frame sent", 32'(rises - base), 32'd32);

        // Retained sample sent on re-enable with the new divider
        push_sample(32'hC3C3_5A5A);
        exp_period = 8;
        i_enable = 1'b1;
        repeat (5) @(negedge clk);
        i_enable = 1'b0;
        wait_idle();

        // Asynchronous reset mid-frame
        i_clk_div  = 8'd1;
        exp_period = 4;
        push_sample(32'hFFFF_FFFF);
        i_enable = 1'b1;
        repeat (70) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst outputs", {28'd0, o_sck, o_ws, o_sd, o_busy}, 32'd0);
        check("midrst ready", 32'(o_sample_ready), 32'd1);
        check("midrst underrun", 32'(o_underrun), 32'd0);
        exp_q.delete();
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
- Transmit-side I2S frame controller behind the APB register block of the I2S peripheral.
- Accepts stereo samples over a valid/ready handshake into a one-entry holding buffer and generates bit clock, word select and serial data.
- Bit clock is derived from the system clock by a programmable divider.
- Sequences frame start and stop, reloads the shifter at frame boundaries and flags underruns to the register block.

Parameters:
- DATA_W, 16: bits per channel; frame is 2*DATA_W bits, left channel then right channel.
- DIV_W, 8: width of the clock-divider configuration input.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  run request from the control register.
- i_clk_div  in  DIV_W  divider value; SCK half period is i_clk_div+1 cycles.
- i_sample_valid  in  1  sample handshake valid.
- i_sample_data  in  2*DATA_W  {left, right}; left occupies the MSBs.
- o_sample_ready  out  1  holding buffer empty; asserted in any state.
- o_sck  out  1  I2S bit clock.
- o_ws  out  1  I2S word select; 0 = left, 1 = right.
- o_sd  out  1  I2S serial data, MSB first.
- o_busy  out  1  state != IDLE.
- o_underrun  out  1  sticky underrun flag.
- i_underrun_clr  in  1  clears o_underrun.

Behaviour:
- Reset (async, immediate, also mid-frame): state=IDLE, buffer empty, o_sck=0, o_ws=0, o_sd=0, o_busy=0, o_underrun=0, o_sample_ready=1.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - o_sample_ready = buffer empty, from registered state only; there is no combinational path from valid.
  - A buffer drained into the shifter in cycle N raises ready in cycle N+1.
- States:
  - IDLE: o_sck, o_ws, o_sd held at 0.
    - IDLE->RUN when i_enable=1 and the buffer is full.
    - In that same cycle: i_clk_div is latched, buffer moves to the shifter, slot=0, half-period counter=0.
    - o_sd shows frame bit 2*DATA_W-1 on the next cycle.
  - RUN:
    - Half-period counter counts 0..div_latched; at terminal count it wraps and o_sck toggles.
    - A falling toggle of o_sck advances the slot; o_ws and o_sd update in the same cycle as the falling SCK.
    - Slot s drives o_sd = frame[2*DATA_W-1-s].
    - o_ws=1 for s in [DATA_W-1, 2*DATA_W-2], else 0; WS leads each channel MSB by one bit (standard I2S).
    - At the falling edge leaving slot 2*DATA_W-1:
      - If i_enable=0: go to IDLE (outputs 0).
      - Else, buffer full: load buffer into shifter, slot=0.
      - Else: load zeros, slot=0, set o_underrun.
  - i_enable deasserted mid-frame: the current frame completes fully before IDLE; no truncation.
- i_clk_div changes while busy are ignored until the next IDLE->RUN.
- Timing:
  - Bit period = 2*(div+1) cycles.
  - Frame = 4*DATA_W*(div+1) cycles.
  - div=0 gives o_sck toggling every cycle.
- o_underrun:
  - Set has priority over a simultaneous i_underrun_clr.
  - Clear takes effect the cycle after i_underrun_clr.
- Buffer contents are retained across disable; a sample accepted while IDLE is transmitted on the next enable.

Decomposition:
- Package i2s_pkg:
  - state enum (IDLE, RUN);
  - DATA_W/DIV_W defaults;
  - frame length constant;
  - slot-index width function.
- Sub-module i2s_clk_gen: divider counter, o_sck register, rise/fall strobes; inputs div_latched and run.

Test Plan:
All scenarios use DATA_W=16, i_clk_div=1 (bit period 4 cycles, frame 128 cycles) unless stated.
1. Reset: hold i_rst 5 cycles and release -> o_sck/o_ws/o_sd/o_busy/o_underrun=0, o_sample_ready=1; assert i_rst mid-frame -> same values in the same cycle.
2. Single frame: push 0xA5A5_3C3C, raise i_enable.
   - o_sd serialises 1010010110100101 then 0011110000111100, one bit per 4 cycles.
   - o_ws rises at slot 15, falls at slot 31.
   - o_sck period = 4 cycles.
3. Streaming: push a new sample whenever o_sample_ready=1 with i_clk_div=0 -> frames back-to-back, no underrun; ready rises exactly 1 cycle after each frame-boundary load.
4. Underrun: push one sample only, keep i_enable=1 -> second frame o_sd all 0, o_underrun=1 from the frame-boundary cycle.
   - Pulse i_underrun_clr -> flag clears next cycle.
   - clr coincident with a new underrun -> flag stays 1.
5. Disable mid-frame: drop i_enable at slot 10 -> frame runs to slot 31, then IDLE with outputs 0 and o_busy=0.
   - i_clk_div changed mid-frame -> SCK period unchanged until re-enable.
